// File: rtl/hazard_unit_pkg.sv
// Shared types and helpers for the RV32I hazard unit.
// Optional forwarding is enabled by defining HAZARD_FWD_EN.
package hazard_unit_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    function automatic logic reg_match(
        input logic                 uses,
        input logic                 wr,
        input logic [REG_IDX_W-1:0] rd,
        input logic [REG_IDX_W-1:0] rs
    );
        return uses & wr & (rd == rs) & (rd != REG_ZERO);
    endfunction

    // Newest producer wins; a MEM-stage load has its data by WB.
    function automatic fwd_sel_t fwd_pick(
        input logic hit_ex,
        input logic hit_mem
    );
        if (hit_ex)
            return FWD_MEM;
        else if (hit_mem)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter with enable.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (en && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forward control for the 5-stage RV32I pipeline.
// HAZARD_FWD_EN selects forwarding; otherwise every RAW hazard stalls.
import hazard_unit_pkg::*;

module hazard_unit #(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rs1_id,
    input  logic [REG_IDX_W-1:0] rs2_id,
    input  logic                 uses_rs1_id,
    input  logic                 uses_rs2_id,
    input  logic [REG_IDX_W-1:0] rd_ex,
    input  logic                 im_to_rf_ex,
    input  logic                 load_ex,
    input  logic                 branch_taken_ex,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic [1:0]           fwd_a_sel,
    output logic [1:0]           fwd_b_sel,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    // WB needs no tracking: the regfile is write-first.
    logic [REG_IDX_W-1:0] rd_mem;
    logic                 wr_mem;

    logic hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
    logic hit_ex, hit_mem, load_use, hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_mem <= REG_ZERO;
            wr_mem <= 1'b0;
        end else begin
            rd_mem <= rd_ex;
            wr_mem <= im_to_rf_ex;
        end
    end

    always_comb begin
        hit_ex_a  = reg_match(uses_rs1_id, im_to_rf_ex, rd_ex, rs1_id);
        hit_ex_b  = reg_match(uses_rs2_id, im_to_rf_ex, rd_ex, rs2_id);
        hit_mem_a = reg_match(uses_rs1_id, wr_mem, rd_mem, rs1_id);
        hit_mem_b = reg_match(uses_rs2_id, wr_mem, rd_mem, rs2_id);
        hit_ex    = hit_ex_a | hit_ex_b;
        hit_mem   = hit_mem_a | hit_mem_b;
        load_use  = load_ex & hit_ex;
    end

`ifdef HAZARD_FWD_EN
    assign hazard = load_use;
`else
    assign hazard = load_use | hit_ex | hit_mem;
`endif

    // Gated by rst so a reset mid-stall clears outputs at once.
    assign flush_if_id = ~rst & branch_taken_ex;
    assign flush_id_ex = ~rst & (branch_taken_ex | hazard);
    assign stall_if    = ~rst & ~branch_taken_ex & hazard;
    assign stall_id    = stall_if;

`ifdef HAZARD_FWD_EN
    fwd_sel_t fwd_a_q, fwd_b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else if (flush_id_ex) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= fwd_pick(hit_ex_a, hit_mem_a);
            fwd_b_q <= fwd_pick(hit_ex_b, hit_mem_b);
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;
`else
    assign fwd_a_sel = FWD_RF;
    assign fwd_b_sel = FWD_RF;
`endif

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (stall_id),
        .cnt (stall_cnt)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .en  (flush_if_id),
        .cnt (flush_cnt)
    );

endmodule
